// File: rtl/core_config_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_config_pkg : shared core widths, ALU command set and alu1 FSM types   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package core_config_pkg;

    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int ALU1_SHIFT_STEP = 4;

    // Encodings 10..15 are unused and are reported as unsupported by alu1.
    typedef enum logic [3:0] {
        c_ADD  = 4'd0,
        c_SUB  = 4'd1,
        c_AND  = 4'd2,
        c_OR   = 4'd3,
        c_XOR  = 4'd4,
        c_SLT  = 4'd5,
        c_SLTU = 4'd6,
        c_SLL  = 4'd7,
        c_SRL  = 4'd8,
        c_SRA  = 4'd9
    } alu_commands_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu1_state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } alu1_shmode_t;

    function automatic logic alu1_is_shift(input alu_commands_t c);
        return (c == c_SLL) || (c == c_SRL) || (c == c_SRA);
    endfunction

    function automatic logic alu1_is_supported(input alu_commands_t c);
        return (c <= c_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu1_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu1_shifter : one combinational barrel step of 0..SHIFT_STEP bit positions|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu1_shifter
    import core_config_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic [XLEN-1:0]               i_work,
    input  logic [$clog2(SHIFT_STEP):0]   i_dist,
    input  alu1_shmode_t                  i_mode,
    input  logic                          i_sign,
    output logic [XLEN-1:0]               o_work
);

    logic [2*XLEN-1:0] w_ext;

    always_comb begin
        // Right shifts pull the fill from the upper half, so SRA keeps the sign.
        w_ext = {{XLEN{i_sign & (i_mode == SH_SRA)}}, i_work} >> i_dist;
        case (i_mode)
            SH_SLL:  o_work = i_work << i_dist;
            default: o_work = w_ext[XLEN-1:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu1 : integer ALU with compare and iterative shifter, held-result output  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu1
    import core_config_pkg::*;
#(
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int SHIFT_STEP = core_config_pkg::ALU1_SHIFT_STEP,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  alu_commands_t         cmd,
    input  logic [XLEN-1:0]       arg0,
    input  logic [XLEN-1:0]       arg1,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  busy,
    output logic                  i_error,
    output logic [XLEN-1:0]       res,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  valid,
    output logic                  o_error,
    input  logic                  clear,
    input  logic                  flush
);

    localparam int RW = $clog2(XLEN);
    localparam int DW = $clog2(SHIFT_STEP) + 1;

    alu1_state_t           r_state;
    alu1_state_t           w_state_nxt;
    logic [XLEN-1:0]       r_res;
    logic [XLEN-1:0]       r_work;
    logic [RW-1:0]         r_rem;
    logic [REG_ADDR_W-1:0] r_o_rd;
    logic                  r_valid;
    logic                  r_o_error;
    logic                  r_i_error;
    logic                  r_sign;
    alu1_shmode_t          r_mode;
    alu1_shmode_t          w_mode_in;

    logic [XLEN:0]         w_sum;
    logic [XLEN:0]         w_diff;
    logic                  w_lt_s;
    logic [XLEN-1:0]       w_alu_res;
    logic                  w_alu_flag;
    logic [RW-1:0]         w_shamt;
    logic [DW-1:0]         w_dist;
    logic [RW-1:0]         w_rem_nxt;
    logic [XLEN-1:0]       w_shifted;
    logic                  w_accept;

    assign w_sum    = {1'b0, arg0} + {1'b0, arg1};
    assign w_diff   = {1'b0, arg0} - {1'b0, arg1};
    assign w_lt_s   = (arg0[XLEN-1] ^ arg1[XLEN-1]) ? arg0[XLEN-1] : w_diff[XLEN-1];
    assign w_shamt  = arg1[RW-1:0];
    assign w_accept = (r_state == IDLE) && issue && !flush && alu1_is_supported(cmd);

    // Bit XLEN of the subtraction is the borrow, which is also the unsigned lt.
    always_comb begin
        w_alu_res  = '0;
        w_alu_flag = 1'b0;
        case (cmd)
            c_ADD:   begin w_alu_res = w_sum[XLEN-1:0];  w_alu_flag = w_sum[XLEN];  end
            c_SUB:   begin w_alu_res = w_diff[XLEN-1:0]; w_alu_flag = w_diff[XLEN]; end
            c_AND:   w_alu_res = arg0 & arg1;
            c_OR:    w_alu_res = arg0 | arg1;
            c_XOR:   w_alu_res = arg0 ^ arg1;
            c_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            c_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, w_diff[XLEN]};
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        case (cmd)
            c_SRL:   w_mode_in = SH_SRL;
            c_SRA:   w_mode_in = SH_SRA;
            default: w_mode_in = SH_SLL;
        endcase
    end

    assign w_dist    = (int'(r_rem) >= SHIFT_STEP) ? DW'(SHIFT_STEP) : DW'(r_rem);
    assign w_rem_nxt = r_rem - RW'(w_dist);

    alu1_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .i_work (r_work),
        .i_dist (w_dist),
        .i_mode (r_mode),
        .i_sign (r_sign),
        .o_work (w_shifted)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (alu1_is_shift(cmd) && (w_shamt != '0)) w_state_nxt = SHIFT;
                    else                                       w_state_nxt = DONE;
                end
            end
            SHIFT:   if (w_rem_nxt == '0) w_state_nxt = DONE;
            DONE:    if (clear) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_res     <= '0;
            r_work    <= '0;
            r_rem     <= '0;
            r_o_rd    <= '0;
            r_valid   <= 1'b0;
            r_o_error <= 1'b0;
            r_i_error <= 1'b0;
            r_sign    <= 1'b0;
            r_mode    <= SH_SLL;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= (w_state_nxt == DONE);
            r_i_error <= (r_state == IDLE) && issue && !flush && !alu1_is_supported(cmd);
            // Every return to IDLE leaves the result port at its reset values.
            if (w_state_nxt == IDLE) begin
                r_res     <= '0;
                r_o_rd    <= '0;
                r_o_error <= 1'b0;
            end else if (r_state == IDLE) begin
                r_o_rd <= i_rd;
                if (alu1_is_shift(cmd)) begin
                    r_work    <= arg0;
                    r_rem     <= w_shamt;
                    r_mode    <= w_mode_in;
                    r_sign    <= arg0[XLEN-1];
                    r_o_error <= 1'b0;
                    if (w_shamt == '0) r_res <= arg0;
                end else begin
                    r_res     <= w_alu_res;
                    r_o_error <= w_alu_flag;
                end
            end else if (r_state == SHIFT) begin
                r_work <= w_shifted;
                r_rem  <= w_rem_nxt;
                if (w_rem_nxt == '0) r_res <= w_shifted;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign valid   = r_valid;
    assign res     = r_res;
    assign o_rd    = r_o_rd;
    assign o_error = r_o_error;
    assign i_error = r_i_error;

endmodule
`default_nettype wire

// File: tb/tb_alu1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu1 : directed-vector bench for alu1 with hand-computed expectations   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_alu1;
    import core_config_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue;
    alu_commands_t cmd;
    logic [31:0]   arg0;
    logic [31:0]   arg1;
    logic [4:0]    i_rd;
    logic          busy;
    logic          i_error;
    logic [31:0]   res;
    logic [4:0]    o_rd;
    logic          valid;
    logic          o_error;
    logic          clear;
    logic          flush;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu1 #(.XLEN(32), .SHIFT_STEP(4), .REG_ADDR_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .issue   (issue),
        .cmd     (cmd),
        .arg0    (arg0),
        .arg1    (arg1),
        .i_rd    (i_rd),
        .busy    (busy),
        .i_error (i_error),
        .res     (res),
        .o_rd    (o_rd),
        .valid   (valid),
        .o_error (o_error),
        .clear   (clear),
        .flush   (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts and ends on a negedge; issue is high for exactly one posedge.
    task automatic issue_op(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        cmd = c; arg0 = a; arg1 = b; i_rd = rd; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
    endtask

    // Counts cycles from the issue edge (that edge counts as 1) until valid.
    task automatic wait_valid(output int n);
        n = 1;
        while (!valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!valid) chk("valid_timeout", {31'd0, valid}, 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_valid", {31'd0, valid}, 32'd0);
        chk("clear_res", res, 32'd0);
    endtask

    task automatic run_op(input string tag, input alu_commands_t c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int lat;
        issue_op(c, a, b, 5'd3);
        wait_valid(lat);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_oerr"}, {31'd0, o_error}, {31'd0, exp_err});
        chk({tag, "_lat"}, lat, exp_lat);
        do_clear();
    endtask

    initial begin
        int  lat;
        logic seen;
        rst = 1'b1; issue = 1'b0; cmd = c_ADD; arg0 = '0; arg1 = '0; i_rd = '0;
        clear = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_ord", {27'd0, o_rd}, 32'd0);
        chk("rst_oerr", {31'd0, o_error}, 32'd0);
        chk("rst_ierr", {31'd0, i_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD with carry-out, held until clear
        issue_op(c_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5);
        chk("add_valid", {31'd0, valid}, 32'd1);
        chk("add_res", res, 32'h0);
        chk("add_oerr", {31'd0, o_error}, 32'd1);
        chk("add_ord", {27'd0, o_rd}, 32'd5);
        chk("add_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        chk("add_hold_valid", {31'd0, valid}, 32'd1);
        chk("add_hold_res", res, 32'h0);
        do_clear();
        chk("add_cleared_busy", {31'd0, busy}, 32'd0);

        run_op("sub_borrow", c_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 1);
        run_op("sub_plain", c_SUB, 32'd7, 32'd5, 32'd2, 1'b0, 1);
        run_op("and", c_AND, 32'hF0F0_FF00, 32'hFF00_0FF0, 32'hF000_0F00, 1'b0, 1);
        run_op("or", c_OR, 32'hF0F0_0000, 32'h0000_1234, 32'hF0F0_1234, 1'b0, 1);
        run_op("xor", c_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
        run_op("slt_neg", c_SLT, 32'hFFFF_FFFF, 32'h1, 32'd1, 1'b0, 1);
        run_op("sltu_neg", c_SLTU, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0, 1);
        run_op("slt_pos", c_SLT, 32'h1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        run_op("sltu_pos", c_SLTU, 32'h1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
        run_op("sll0", c_SLL, 32'h1, 32'd0, 32'h1, 1'b0, 1);
        run_op("sra31", c_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 9);
        run_op("srl31", c_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 9);
        run_op("sll5", c_SLL, 32'h1, 32'd5, 32'h0000_0020, 1'b0, 3);
        run_op("sra8", c_SRA, 32'h8000_0000, 32'd8, 32'hFF80_0000, 1'b0, 3);
        run_op("sra_pos", c_SRA, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0, 2);
        run_op("sll_shamt_wrap", c_SLL, 32'h1, 32'h24, 32'h0000_0010, 1'b0, 2);

        // unsupported command
        issue_op(alu_commands_t'(4'd12), 32'h1, 32'h2, 5'd1);
        chk("bad_ierr", {31'd0, i_error}, 32'd1);
        chk("bad_valid", {31'd0, valid}, 32'd0);
        chk("bad_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("bad_ierr_pulse", {31'd0, i_error}, 32'd0);
        chk("bad_valid2", {31'd0, valid}, 32'd0);

        // issue during DONE is ignored; back-to-back after clear
        issue_op(c_ADD, 32'd3, 32'd4, 5'd7);
        cmd = c_XOR; arg0 = 32'hF0; arg1 = 32'hFF; i_rd = 5'd9; issue = 1'b1;
        repeat (5) @(negedge clk);
        issue = 1'b0;
        chk("done_hold_res", res, 32'd7);
        chk("done_hold_ord", {27'd0, o_rd}, 32'd7);
        chk("done_hold_valid", {31'd0, valid}, 32'd1);
        do_clear();
        issue_op(c_XOR, 32'hF0, 32'hFF, 5'd9);
        chk("b2b_res", res, 32'h0F);
        chk("b2b_ord", {27'd0, o_rd}, 32'd9);
        do_clear();

        // flush in cycle 3 of SLL by 20
        issue_op(c_SLL, 32'h1, 32'd20, 5'd4);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        chk("flush_ord", {27'd0, o_rd}, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= valid;
        end
        chk("flush_no_valid", {31'd0, seen}, 32'd0);

        // async reset mid-SHIFT
        issue_op(c_SRA, 32'h8000_0000, 32'd31, 5'd6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_ord", {27'd0, o_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= valid | busy;
        end
        chk("arst_quiet", {31'd0, seen}, 32'd0);

        // issue together with flush is dropped
        flush = 1'b1;
        issue_op(c_ADD, 32'd1, 32'd1, 5'd2);
        flush = 1'b0;
        chk("flush_issue_busy", {31'd0, busy}, 32'd0);
        chk("flush_issue_valid", {31'd0, valid}, 32'd0);
        run_op("after_flush", c_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu1.md
Name: alu1

Overview:
alu1 is the second-generation integer ALU slot between the issuer and the committer. It is parametrised in data width and shifter step. It adds signed and unsigned compare and an iterative multi-cycle shifter to the basic ADD/SUB/AND/OR/XOR set. Each result is held in an output register until the committer acknowledges it with clear, and a flush input aborts any operation in flight.

Parameters:
XLEN, core_config_pkg::XLEN (32), datapath width; must be a power of 2.
SHIFT_STEP, 4, maximum shift distance applied per SHIFT cycle; power of 2, 1..XLEN.
REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), destination register index width.

Ports:
clk  in  1  core clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
issue  in  1  issuer presents a valid operation this cycle.
cmd  in  alu_commands_t  operation select.
arg0  in  XLEN  operand A; shift source for shift ops.
arg1  in  XLEN  operand B; shamt = arg1[$clog2(XLEN)-1:0] for shift ops.
i_rd  in  REG_ADDR_W  destination register tag.
busy  out  1  unit is not IDLE; the issuer must not issue.
i_error  out  1  one-cycle pulse after an issue with an unsupported cmd.
res  out  XLEN  result, stable while valid=1.
o_rd  out  REG_ADDR_W  tag for res.
valid  out  1  result is ready for the committer.
o_error  out  1  carry-out for ADD, borrow for SUB, 0 for all other ops.
clear  in  1  committer has consumed the result.
flush  in  1  pipeline flush; aborts current operation.

Behaviour:
- Reset (async, rst=1): state=IDLE; res=0, o_rd=0, valid=0, o_error=0, i_error=0. busy=0 because it is decoded from state.
- FSM states: IDLE, SHIFT, DONE. busy=(state!=IDLE). valid=(state==DONE), registered with state.
- IDLE, issue=1, single-cycle op (ADD, SUB, AND, OR, XOR, SLT, SLTU):
  - Compute with an XLEN+1-bit add/sub.
  - Latch res, o_error and o_rd at the edge; go to DONE.
  - valid rises 1 cycle after issue.
- SLT and SLTU: res = {XLEN-1 zeros, lt}. SLT compares signed, SLTU unsigned.
- IDLE, issue=1, shift op (SLL, SRL, SRA):
  - Latch arg0 into the work register, remaining=shamt, o_rd=i_rd.
  - shamt==0: go directly to DONE with res=arg0.
  - Otherwise go to SHIFT.
- SHIFT: each cycle shift the work register by d=min(SHIFT_STEP, remaining); remaining -= d.
  - SRA fills with the original sign bit; SRL and SLL fill with zeros.
  - When remaining becomes 0: res=work, go to DONE.
  - Shift latency = 1 + ceil(shamt/SHIFT_STEP) cycles from issue to valid.
- IDLE, issue=1, unsupported cmd: i_error=1 for exactly one cycle; stay in IDLE; valid stays 0.
- DONE: hold res, o_rd and o_error.
  - clear=1: go to IDLE next cycle; valid falls and res is zeroed.
  - issue while in DONE is ignored; the issuer must honour busy.
- clear in IDLE or SHIFT is ignored.
- flush=1 in any state: go to IDLE next cycle; valid=0, no result emitted. flush has priority over clear and issue.
- issue with flush in the same cycle: the operation is dropped.
- Back-to-back: clear in DONE and issue in the following cycle (IDLE) is accepted. Peak throughput is 1 op per 2 cycles.
- Reset asserted mid-SHIFT: immediate return to IDLE; no valid produced.

Decomposition:
- core_config_pkg:
  - extend alu_commands_t with c_SLT, c_SLTU, c_SLL, c_SRL, c_SRA;
  - add constant ALU1_SHIFT_STEP;
  - add alu1_state_t enum {IDLE, SHIFT, DONE}.
- Sub-module alu1_shifter:
  - one-step barrel stage, combinational;
  - inputs: work, distance d (0..SHIFT_STEP), mode, sign fill;
  - output: shifted work.
- The FSM, counter and output registers stay in alu1.

Test Plan:
1. ADD arg0=0xFFFFFFFF, arg1=0x00000001, i_rd=5 -> next cycle valid=1, res=0x00000000, o_error=1, o_rd=5; held until clear, then valid=0 one cycle later.
2. SRA arg0=0x80000000, shamt=31, SHIFT_STEP=4 -> busy for 9 cycles, valid at cycle 9, res=0xFFFFFFFF. SRL with the same operands -> res=0x00000001.
3. SLT 0xFFFFFFFF vs 0x00000001 -> res=1. SLTU with the same operands -> res=0. SLL 0x1 by 0 -> res=0x1 with valid after 1 cycle.
4. Unsupported cmd with issue=1 -> i_error pulse exactly 1 cycle, valid stays 0, busy stays 0.
5. Result in DONE, clear withheld 5 cycles, a second issue presented -> res unchanged and second op ignored. After clear, a re-issued second op completes normally.
6. flush at cycle 3 of SLL by 20, and separately rst pulsed mid-SHIFT -> IDLE next cycle (immediately for rst), valid never asserted, all outputs at reset values.
